pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the program-counter and address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of return-stack entries.
REQ-003 The block SHALL have parameter RST_VEC, default 0, giving the PC value loaded at reset.
REQ-004 CLK  in  1  clock; all state changes on the rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 EN  in  1  advance enable; when 0, no state changes.
REQ-007 OP  in  3  operation code: 000 HOLD, 001 INC, 010 BR, 011 JMP, 100 CALL, 101 RET; 110 and 111 are treated as HOLD.
REQ-008 COND  in  1  branch condition, used by BR only.
REQ-009 OFF  in  WIDTH  signed two's-complement branch offset.
REQ-010 TGT  in  WIDTH  absolute target for JMP and CALL.
REQ-011 PC  out  WIDTH  current program counter, registered.
REQ-012 SP  out  clog2(DEPTH)+1  return-stack occupancy, range 0..DEPTH.
REQ-013 OVF  out  1  sticky stack-overflow flag.
REQ-014 UNF  out  1  sticky stack-underflow flag.

Function
REQ-015 Each op SHALL take effect on the rising CLK edge where EN=1; the new PC is visible on PC one cycle after the op is presented (latency 1).
REQ-016 HOLD SHALL leave PC, SP and the stack unchanged.
REQ-017 INC SHALL set PC to PC+1 modulo 2^WIDTH, so the maximum value wraps to 0.
REQ-018 BR with COND=1 SHALL set PC to PC+1+sext(OFF) modulo 2^WIDTH.
REQ-019 BR with COND=0 SHALL behave exactly as INC.
REQ-020 JMP SHALL set PC to TGT.
REQ-021 CALL with SP<DEPTH SHALL, in the same edge: write PC+1 (wrapped) to stack[SP], increment SP, and set PC to TGT.
REQ-022 CALL with SP=DEPTH SHALL leave PC, SP and the stack unchanged and set OVF.
REQ-023 RET with SP>0 SHALL set PC to stack[SP-1] and decrement SP.
REQ-024 RET with SP=0 SHALL leave PC and SP unchanged and set UNF.
REQ-025 OVF and UNF SHALL be cleared only by RST; once set, they stay set and do not block later legal ops.
REQ-026 EN=0 SHALL freeze all state, including the flags, regardless of OP.
REQ-027 Stack entries SHALL not be cleared on pop; entries at index SP and above are don't-care and SHALL never drive PC.
REQ-028 Arithmetic SHALL be WIDTH bits wide, with carry and overflow discarded.

Reset
REQ-029 RST=1 SHALL immediately, without waiting for a clock edge, force PC=RST_VEC, SP=0, OVF=0 and UNF=0.
REQ-030 The stack storage array SHALL not need reset.
REQ-031 RST asserted mid-sequence (for example between a CALL and its RET) SHALL abandon the stack contents, with no partial update.
REQ-032 The first op after RST deasserts SHALL act on PC=RST_VEC.

Structure
REQ-033 The opcode constants (HOLD, INC, BR, JMP, CALL, RET) SHALL live in the shared CPU package, alongside the default WIDTH.
REQ-034 There SHALL be exactly one sub-module, ret_stack: a DEPTH x WIDTH LIFO with push, pop, full and empty outputs and SP.
REQ-035 The top level SHALL contain the PC register, next-PC mux, adder and flag logic; no other hierarchy.

Verification
REQ-036 Reset and increment: RST pulse, then INC x3 -> PC 0,1,2,3. Then JMP TGT=FF followed by INC -> PC=00 (wrap).
REQ-037 Branch: PC=10, BR COND=1 OFF=FE -> PC=0F. Then BR COND=0 -> PC=10. Then BR COND=1 OFF=7F from PC=F0 -> PC=70 (wrap).
REQ-038 Nested calls: from PC=05, CALL 20, CALL 40, RET, RET -> PC sequence 20,40,21,06, with SP sequence 1,2,1,0.
REQ-039 Overflow and underflow: 5 CALLs (DEPTH=4) -> SP=4, OVF=1, PC unchanged on the 5th. Then 4 RETs followed by a 5th RET -> SP=0, UNF=1, PC unchanged on the 5th, and OVF still 1.
REQ-040 Enable and asynchronous reset: EN=0 with OP=JMP TGT=33 -> PC unchanged. Then RST asserted between clock edges after CALL -> PC=RST_VEC, SP=0 and flags 0 before the next edge.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the program-counter sequencer: opcode encoding and
// the default address width.
package pc_sequencer_pkg;

    localparam int unsigned PC_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_INC  = 3'b001,
        OP_BR   = 3'b010,
        OP_JMP  = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } op_e;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: DEPTH entries of WIDTH bits, occupancy counter SP.
// Storage is not reset; only the occupancy counter is.
module ret_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top_data,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned SPW  = $clog2(DEPTH) + 1;
    localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [SPW-1:0]   sp_m1_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (sp_q == SPW'(DEPTH));
    assign empty     = (sp_q == SPW'(0));
    assign sp        = sp_q;
    assign sp_m1_s   = sp_q - SPW'(1);
    assign top_data  = stack_q[sp_m1_s[IDXW-1:0]];
    // Guard here too so an illegal request can never index past the array.
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty & ~push;

    // Next stack contents and occupancy.
    always_comb begin
        stack_d = stack_q;
        sp_d    = sp_q;
        if (push_ok_s) begin
            stack_d[sp_q[IDXW-1:0]] = push_data;
            sp_d                    = sp_q + SPW'(1);
        end else if (pop_ok_s) begin
            sp_d = sp_m1_s;
        end else begin
            sp_d = sp_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sp_q <= SPW'(0);
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage array; a reset edge never writes so contents are simply abandoned.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            stack_q <= stack_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, next-PC selection, branch adder,
// sticky overflow/underflow flags, with a return stack for CALL/RET.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned           WIDTH   = PC_WIDTH,
    parameter int unsigned           DEPTH   = 4,
    parameter logic [WIDTH-1:0]      RST_VEC = '0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       EN,
    input  logic [2:0]                 OP,
    input  logic                       COND,
    input  logic [WIDTH-1:0]           OFF,
    input  logic [WIDTH-1:0]           TGT,
    output logic [WIDTH-1:0]           PC,
    output logic [$clog2(DEPTH):0]     SP,
    output logic                       OVF,
    output logic                       UNF
);
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic [WIDTH-1:0] pc_inc_s;
    logic [WIDTH-1:0] pc_br_s;
    logic [WIDTH-1:0] top_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;

    // Offset is two's complement, so an unsigned WIDTH-bit add gives sext() for free.
    assign pc_inc_s = pc_q + WIDTH'(1);
    assign pc_br_s  = pc_inc_s + OFF;

    // Next-PC mux, stack requests and sticky flags.
    always_comb begin
        pc_d   = pc_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (EN) begin
            case (OP)
                OP_INC:  pc_d = pc_inc_s;
                OP_BR:   pc_d = COND ? pc_br_s : pc_inc_s;
                OP_JMP:  pc_d = TGT;
                OP_CALL: begin
                    if (!full_s) begin
                        push_s = 1'b1;
                        pc_d   = TGT;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!empty_s) begin
                        pop_s = 1'b1;
                        pc_d  = top_s;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                default: pc_d = pc_q;
            endcase
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and flag registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q  <= RST_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top_data  (top_s),
        .sp        (SP),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign PC  = pc_q;
    assign OVF = ovf_q;
    assign UNF = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, async-reset sequence, and
// randomized ops checked against a queue-based reference model.
module tb_pc_sequencer;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic [2:0] OP;
    logic       COND;
    logic [7:0] OFF;
    logic [7:0] TGT;
    logic [7:0] PC;
    logic [2:0] SP;
    logic       OVF;
    logic       UNF;

    int vectors;
    int miscompares;

    pc_sequencer #(.WIDTH(8), .DEPTH(4), .RST_VEC(8'h00)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .OP   (OP),
        .COND (COND),
        .OFF  (OFF),
        .TGT  (TGT),
        .PC   (PC),
        .SP   (SP),
        .OVF  (OVF),
        .UNF  (UNF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       en;
        logic [2:0] op;
        logic       cond;
        logic [7:0] off;
        logic [7:0] tgt;
        logic [7:0] pc;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    logic [7:0] m_pc;
    logic [7:0] m_stack[$];
    logic       m_ovf;
    logic       m_unf;

    task automatic add(input logic en, input logic [2:0] op, input logic cond,
                       input logic [7:0] off, input logic [7:0] tgt,
                       input logic [7:0] pc, input logic [2:0] sp,
                       input logic ovf, input logic unf);
        vec_t v;
        v.en = en; v.op = op; v.cond = cond; v.off = off; v.tgt = tgt;
        v.pc = pc; v.sp = sp; v.ovf = ovf; v.unf = unf;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] pc, input logic [2:0] sp,
                         input logic ovf, input logic unf);
        vectors++;
        if (PC !== pc || SP !== sp || OVF !== ovf || UNF !== unf) begin
            miscompares++;
            $display("FAIL %s: got PC=%h SP=%0d OVF=%b UNF=%b, expected PC=%h SP=%0d OVF=%b UNF=%b",
                     name, PC, SP, OVF, UNF, pc, sp, ovf, unf);
        end
    endtask

    // Drive one op just after a rising edge, then let the next edge consume it.
    task automatic step(input logic en, input logic [2:0] op, input logic cond,
                        input logic [7:0] off, input logic [7:0] tgt);
        EN = en; OP = op; COND = cond; OFF = off; TGT = tgt;
        @(posedge CLK);
        #1;
    endtask

    function automatic void model_reset();
        m_pc  = 8'h00;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void model_step(input logic en, input logic [2:0] op, input logic cond,
                                       input logic [7:0] off, input logic [7:0] tgt);
        int nxt;
        if (!en) return;
        case (op)
            3'd1: m_pc = 8'((int'(m_pc) + 1) % 256);
            3'd2: begin
                nxt = int'(m_pc) + 1;
                if (cond) nxt = nxt + ($signed(off) < 0 ? int'(off) - 256 : int'(off));
                m_pc = 8'(((nxt % 256) + 256) % 256);
            end
            3'd3: m_pc = tgt;
            3'd4: begin
                if (m_stack.size() < 4) begin
                    m_stack.push_back(8'((int'(m_pc) + 1) % 256));
                    m_pc = tgt;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            3'd5: begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else m_unf = 1'b1;
            end
            default: ;
        endcase
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST = 1'b1; EN = 1'b0; OP = 3'd0; COND = 1'b0; OFF = 8'h00; TGT = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
        RST = 1'b0;

        // Increment and wrap
        add(1'b1, 3'd1, 1'b0, 8'h00, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0);
        add(1'b1, 3'd1, 1'b0, 8'h00, 8'h00, 8'h02, 3'd0, 1'b0, 1'b0);
        add(1'b1, 3'd1, 1'b0, 8'h00, 8'h00, 8'h03, 3'd0, 1'b0, 1'b0);
        add(1'b1, 3'd3, 1'b0, 8'h00, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b0);
        add(1'b1, 3'd1, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        // Branches
        add(1'b1, 3'd3, 1'b0, 8'h00, 8'h10, 8'h10, 3'd0, 1'b0, 1'b0);
        add(1'b1, 3'd2, 1'b1, 8'hFE, 8'h00, 8'h0F, 3'd0, 1'b0, 1'b0);
        add(1'b1, 3'd2, 1'b0, 8'hFE, 8'h00, 8'h10, 3'd0, 1'b0, 1'b0);
        add(1'b1, 3'd3, 1'b0, 8'h00, 8'hF0, 8'hF0, 3'd0, 1'b0, 1'b0);
        add(1'b1, 3'd2, 1'b1, 8'h7F, 8'h00, 8'h70, 3'd0, 1'b0, 1'b0);
        // Nested calls
        add(1'b1, 3'd3, 1'b0, 8'h00, 8'h05, 8'h05, 3'd0, 1'b0, 1'b0);
        add(1'b1, 3'd4, 1'b0, 8'h00, 8'h20, 8'h20, 3'd1, 1'b0, 1'b0);
        add(1'b1, 3'd4, 1'b0, 8'h00, 8'h40, 8'h40, 3'd2, 1'b0, 1'b0);
        add(1'b1, 3'd5, 1'b0, 8'h00, 8'h00, 8'h21, 3'd1, 1'b0, 1'b0);
        add(1'b1, 3'd5, 1'b0, 8'h00, 8'h00, 8'h06, 3'd0, 1'b0, 1'b0);
        // Overflow then underflow
        add(1'b1, 3'd4, 1'b0, 8'h00, 8'h10, 8'h10, 3'd1, 1'b0, 1'b0);
        add(1'b1, 3'd4, 1'b0, 8'h00, 8'h20, 8'h20, 3'd2, 1'b0, 1'b0);
        add(1'b1, 3'd4, 1'b0, 8'h00, 8'h30, 8'h30, 3'd3, 1'b0, 1'b0);
        add(1'b1, 3'd4, 1'b0, 8'h00, 8'h40, 8'h40, 3'd4, 1'b0, 1'b0);
        add(1'b1, 3'd4, 1'b0, 8'h00, 8'h50, 8'h40, 3'd4, 1'b1, 1'b0);
        add(1'b1, 3'd5, 1'b0, 8'h00, 8'h00, 8'h31, 3'd3, 1'b1, 1'b0);
        add(1'b1, 3'd5, 1'b0, 8'h00, 8'h00, 8'h21, 3'd2, 1'b1, 1'b0);
        add(1'b1, 3'd5, 1'b0, 8'h00, 8'h00, 8'h11, 3'd1, 1'b1, 1'b0);
        add(1'b1, 3'd5, 1'b0, 8'h00, 8'h00, 8'h07, 3'd0, 1'b1, 1'b0);
        add(1'b1, 3'd5, 1'b0, 8'h00, 8'h00, 8'h07, 3'd0, 1'b1, 1'b1);
        // Hold, reserved opcodes, enable low
        add(1'b1, 3'd0, 1'b0, 8'h00, 8'h99, 8'h07, 3'd0, 1'b1, 1'b1);
        add(1'b1, 3'd6, 1'b1, 8'h05, 8'h99, 8'h07, 3'd0, 1'b1, 1'b1);
        add(1'b1, 3'd7, 1'b1, 8'h05, 8'h99, 8'h07, 3'd0, 1'b1, 1'b1);
        add(1'b0, 3'd3, 1'b0, 8'h00, 8'h33, 8'h07, 3'd0, 1'b1, 1'b1);
        add(1'b0, 3'd4, 1'b0, 8'h00, 8'h33, 8'h07, 3'd0, 1'b1, 1'b1);
        add(1'b1, 3'd1, 1'b0, 8'h00, 8'h00, 8'h08, 3'd0, 1'b1, 1'b1);

        @(posedge CLK);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].op, tbl[i].cond, tbl[i].off, tbl[i].tgt);
            check($sformatf("table[%0d]", i), tbl[i].pc, tbl[i].sp, tbl[i].ovf, tbl[i].unf);
        end

        // Asynchronous reset between a CALL and its RET
        step(1'b1, 3'd4, 1'b0, 8'h00, 8'h60);
        check("call_before_rst", 8'h60, 3'd1, 1'b1, 1'b1);
        EN = 1'b0;
        #2 RST = 1'b1;
        #1 check("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
        step(1'b1, 3'd1, 1'b0, 8'h00, 8'h00);
        check("first_op_after_rst", 8'h01, 3'd0, 1'b0, 1'b0);
        step(1'b1, 3'd5, 1'b0, 8'h00, 8'h00);
        check("ret_after_rst", 8'h01, 3'd0, 1'b0, 1'b1);

        // Randomized ops against the reference model
        RST = 1'b1;
        #2 RST = 1'b0;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            logic       en;
            logic [2:0] op;
            logic       cond;
            logic [7:0] off;
            logic [7:0] tgt;
            en   = ($urandom_range(9) != 0);
            op   = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(5, 4));
            cond = 1'($urandom_range(1));
            off  = 8'($urandom_range(255));
            tgt  = 8'($urandom_range(255));
            if ($urandom_range(99) == 0) begin
                RST = 1'b1;
                #2 RST = 1'b0;
                model_reset();
            end
            step(en, op, cond, off, tgt);
            model_step(en, op, cond, off, tgt);
            check($sformatf("rand[%0d]", i), m_pc, 3'(m_stack.size()), m_ovf, m_unf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
